// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundle between the commit stage / CSR file and trap_ctrl.
//   master : core side, drives commit/exception/interrupt/CSR-state inputs,
//            receives take/busy, CSR write-back and redirect outputs.
//   slave  : trap_ctrl side (mirror of master).
interface trap_ctrl_if;
    // commit / event inputs
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        exc_valid;
    logic [5:0]  exc_code;
    logic [63:0] exc_tval;
    logic        is_mret;
    logic        mem_busy;
    // interrupt lines and CSR state
    logic        irq_meip;
    logic        irq_msip;
    logic        irq_mtip;
    logic [63:0] mie;
    logic        mstatus_mie;
    logic [63:0] mtvec;
    logic [63:0] mepc_in;
    // controller outputs
    logic        take;
    logic        busy;
    logic        csr_we;
    logic [63:0] csr_mepc;
    logic [63:0] csr_mcause;
    logic [63:0] csr_mtval;
    logic [1:0]  mstatus_op;
    logic        flush;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output commit_valid, commit_pc, exc_valid, exc_code, exc_tval, is_mret, mem_busy,
               irq_meip, irq_msip, irq_mtip, mie, mstatus_mie, mtvec, mepc_in,
        input  take, busy, csr_we, csr_mepc, csr_mcause, csr_mtval, mstatus_op,
               flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  commit_valid, commit_pc, exc_valid, exc_code, exc_tval, is_mret, mem_busy,
               irq_meip, irq_msip, irq_mtip, mie, mstatus_mie, mtvec, mepc_in,
        output take, busy, csr_we, csr_mepc, csr_mcause, csr_mtval, mstatus_op,
               flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / mret exit sequencer.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : trap_ctrl_if.slave (commit/exception/irq inputs, CSR write-back,
//           flush and redirect outputs)
// Build option: define TRAP_CTRL_VECTORED_EN to enable vectored interrupt entry
// (mtvec mode 01 -> base + 4*cause for interrupts). Without it all traps go
// to the mtvec base.
//
// state    | meaning
// IDLE     | waiting for an event at commit; take is evaluated here only
// DRAIN    | event captured, waiting for in-flight data access to finish
// WRITE    | one cycle of CSR write-back (or mstatus restore for mret) + flush
// REDIRECT | one cycle of front-end redirect, then back to IDLE
module trap_ctrl (
    input  logic       clk,
    input  logic       reset,
    trap_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DRAIN    = 2'd1;
    localparam logic [1:0] WRITE    = 2'd2;
    localparam logic [1:0] REDIRECT = 2'd3;

    localparam logic [1:0] KIND_EXC  = 2'd0;
    localparam logic [1:0] KIND_IRQ  = 2'd1;
    localparam logic [1:0] KIND_MRET = 2'd2;

    logic [1:0]  state, state_nx;
    logic [1:0]  kind_q, kind_nx;
    logic [5:0]  cause_q, cause_nx;
    logic [63:0] tval_q, pc_q;
    logic [61:0] mepc_q;

    logic        en_mei, en_msi, en_mti, irq_any, event_any;
    logic [3:0]  irq_code;
    logic [63:0] trap_base, trap_target;

    logic        take, csr_we, flush, redirect_valid;
    logic [1:0]  mstatus_op;
    logic [63:0] csr_mepc, csr_mcause, csr_mtval, redirect_pc;

    // Bits of the CSR views this block never looks at.
    logic unused_bits;
    assign unused_bits = ^{bus.mie[63:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0],
                           bus.mtvec[1:0], bus.mepc_in[1:0]};

    assign en_mei    = bus.mstatus_mie & bus.mie[11] & bus.irq_meip;
    assign en_msi    = bus.mstatus_mie & bus.mie[3]  & bus.irq_msip;
    assign en_mti    = bus.mstatus_mie & bus.mie[7]  & bus.irq_mtip;
    assign irq_any   = en_mei | en_msi | en_mti;
    assign event_any = bus.commit_valid & (bus.exc_valid | irq_any | bus.is_mret);

    always_comb begin
        irq_code = 4'd7;
        if (en_mei)
            irq_code = 4'd11;
        else if (en_msi)
            irq_code = 4'd3;
    end

    always_comb begin
        kind_nx  = KIND_MRET;
        cause_nx = 6'd0;
        if (bus.exc_valid) begin
            kind_nx  = KIND_EXC;
            cause_nx = bus.exc_code;
        end else if (irq_any) begin
            kind_nx  = KIND_IRQ;
            cause_nx = {2'b00, irq_code};
        end
    end

    // Combinational kill of the committing instruction; suppressed in reset.
    assign take = (state == IDLE) & ~reset & event_any;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (event_any) state_nx = DRAIN;
            DRAIN:    if (!bus.mem_busy) state_nx = WRITE;
            WRITE:    state_nx = REDIRECT;
            REDIRECT: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            kind_q  <= KIND_EXC;
            cause_q <= 6'd0;
            tval_q  <= 64'd0;
            pc_q    <= 64'd0;
            mepc_q  <= 62'd0;
        end else begin
            state <= state_nx;
            if (take) begin
                kind_q  <= kind_nx;
                cause_q <= cause_nx;
                tval_q  <= bus.exc_tval;
                pc_q    <= bus.commit_pc;
                mepc_q  <= bus.mepc_in[63:2];
            end
        end
    end

    // mtvec is read live in REDIRECT, not captured with the event.
    assign trap_base = {bus.mtvec[63:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
    assign trap_target = (kind_q == KIND_IRQ && bus.mtvec[1:0] == 2'b01)
                       ? trap_base + {58'd0, cause_q[3:0], 2'b00}
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    always_comb begin
        csr_we         = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        mstatus_op     = 2'b00;
        csr_mepc       = 64'd0;
        csr_mcause     = 64'd0;
        csr_mtval      = 64'd0;
        redirect_pc    = 64'd0;
        case (state)
            WRITE: begin
                flush = 1'b1;
                if (kind_q == KIND_MRET) begin
                    mstatus_op = 2'b10;
                end else begin
                    csr_we     = 1'b1;
                    mstatus_op = 2'b01;
                    csr_mepc   = pc_q;
                    if (kind_q == KIND_EXC) begin
                        csr_mcause = {58'd0, cause_q};
                        csr_mtval  = tval_q;
                    end else begin
                        csr_mcause = {1'b1, 59'd0, cause_q[3:0]};
                    end
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = (kind_q == KIND_MRET) ? {mepc_q, 2'b00} : trap_target;
            end
            default: ;
        endcase
    end

    assign bus.take           = take;
    assign bus.busy           = (state != IDLE);
    assign bus.csr_we         = csr_we;
    assign bus.flush          = flush;
    assign bus.redirect_valid = redirect_valid;
    assign bus.mstatus_op     = mstatus_op;
    assign bus.csr_mepc       = csr_mepc;
    assign bus.csr_mcause     = csr_mcause;
    assign bus.csr_mtval      = csr_mtval;
    assign bus.redirect_pc    = redirect_pc;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl with a timeline reference model
// compared every cycle, plus literal expectations for the scripted events.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trap_ctrl_if tif();
    trap_ctrl dut (.clk(clk), .reset(reset), .bus(tif));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An accepted event is a record; the WRITE cycle is fixed once the drain
    // sees mem_busy low, REDIRECT follows it, then the event retires.
    int          cyc = 0;
    bit          ev_on = 0;
    int          ev_kind;      // 0 exception, 1 interrupt, 2 mret
    int          ev_cause;
    logic [63:0] ev_tval, ev_pc, ev_mepc;
    int          wr_cyc;
    int          pri [3] = '{11, 3, 7};
    int          irq_sel;
    bit          e_take, in_w, in_r;
    logic [63:0] e_mepc, e_mcause, e_mtval, e_rpc, tgt;
    logic [1:0]  e_op;

    function automatic bit irq_line(input int code);
        case (code)
            11:      return tif.irq_meip;
            3:       return tif.irq_msip;
            default: return tif.irq_mtip;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                irq_sel = -1;
                for (int i = 0; i < 3; i++)
                    if (irq_sel < 0 && tif.mstatus_mie && tif.mie[pri[i]] && irq_line(pri[i]))
                        irq_sel = pri[i];
                e_take = !reset && !ev_on && tif.commit_valid
                         && (tif.exc_valid || irq_sel >= 0 || tif.is_mret);
                in_w = ev_on && wr_cyc == cyc;
                in_r = ev_on && wr_cyc >= 0 && cyc == wr_cyc + 1;

                e_op     = in_w ? ((ev_kind == 2) ? 2'b10 : 2'b01) : 2'b00;
                e_mepc   = (in_w && ev_kind != 2) ? ev_pc : 64'd0;
                e_mcause = 64'd0;
                if (in_w && ev_kind == 0) e_mcause = 64'(ev_cause);
                if (in_w && ev_kind == 1) e_mcause = 64'h8000_0000_0000_0000 + 64'(ev_cause);
                e_mtval  = (in_w && ev_kind == 0) ? ev_tval : 64'd0;
                if (ev_kind == 2) begin
                    tgt = ev_mepc & ~64'h3;
                end else begin
                    tgt = tif.mtvec & ~64'h3;
`ifdef TRAP_CTRL_VECTORED_EN
                    if (ev_kind == 1 && tif.mtvec[1:0] == 2'b01) tgt = tgt + 64'(ev_cause) * 4;
`endif
                end
                e_rpc = in_r ? tgt : 64'd0;

                chk("take",           64'(tif.take),           64'(e_take));
                chk("busy",           64'(tif.busy),           64'(ev_on));
                chk("csr_we",         64'(tif.csr_we),         64'(in_w && ev_kind != 2));
                chk("flush",          64'(tif.flush),          64'(in_w));
                chk("mstatus_op",     64'(tif.mstatus_op),     64'(e_op));
                chk("csr_mepc",       tif.csr_mepc,            e_mepc);
                chk("csr_mcause",     tif.csr_mcause,          e_mcause);
                chk("csr_mtval",      tif.csr_mtval,           e_mtval);
                chk("redirect_valid", 64'(tif.redirect_valid), 64'(in_r));
                chk("redirect_pc",    tif.redirect_pc,         e_rpc);

                if (reset) begin
                    ev_on = 0;
                end else if (ev_on) begin
                    if (wr_cyc < 0 && !tif.mem_busy) wr_cyc = cyc + 1;
                    else if (wr_cyc >= 0 && cyc == wr_cyc + 1) ev_on = 0;
                end else if (e_take) begin
                    ev_on   = 1;
                    wr_cyc  = -1;
                    ev_pc   = tif.commit_pc;
                    ev_tval = tif.exc_tval;
                    ev_mepc = tif.mepc_in;
                    if (tif.exc_valid) begin
                        ev_kind = 0; ev_cause = int'(tif.exc_code);
                    end else if (irq_sel >= 0) begin
                        ev_kind = 1; ev_cause = irq_sel;
                    end else begin
                        ev_kind = 2; ev_cause = 0;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    int          t_take, t_we, t_op, t_rd, t_idle;
    logic [63:0] o_mepc, o_mcause, o_mtval, o_rpc;
    logic [1:0]  o_op;
    logic        o_flush;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        tif.commit_valid = 0;
        tif.exc_valid    = 0;
        tif.is_mret      = 0;
    endtask

    // Event inputs are already driven for offset 0. mem_busy is held for nb
    // cycles after capture; noise drives fresh events while busy.
    task automatic run_event(input int nb, input bit noise);
        t_take = -1; t_we = -1; t_op = -1; t_rd = -1; t_idle = -1;
        o_mepc = '0; o_mcause = '0; o_mtval = '0; o_rpc = '0; o_op = '0; o_flush = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0 && tif.take) t_take = 0;
            if (k > 0 && !tif.busy) begin
                t_idle = k;
                break;
            end
            if (tif.csr_we && t_we < 0) begin
                t_we = k; o_mepc = tif.csr_mepc; o_mcause = tif.csr_mcause; o_mtval = tif.csr_mtval;
            end
            if (tif.mstatus_op != 2'b00 && t_op < 0) begin
                t_op = k; o_op = tif.mstatus_op; o_flush = tif.flush;
            end
            if (tif.redirect_valid && t_rd < 0) begin
                t_rd = k; o_rpc = tif.redirect_pc;
            end
            step();
            clear_commit();
            tif.mem_busy = (k + 1 <= nb);
            if (noise && k + 1 <= nb + 2) begin
                tif.commit_valid = 1; tif.exc_valid = 1; tif.is_mret = 1;
                tif.exc_code = 6'h3F; tif.mepc_in = 64'h0;
            end
        end
        chk("event_completes", 64'(t_idle >= 0), 64'd1);
        step();
        clear_commit();
        tif.mem_busy = 0;
    endtask

    task automatic drive_exc(input logic [63:0] pc, input logic [5:0] code, input logic [63:0] tval);
        tif.commit_valid = 1; tif.exc_valid = 1; tif.commit_pc = pc;
        tif.exc_code = code; tif.exc_tval = tval;
    endtask

    task automatic set_irq(input bit mei, input bit msi, input bit mti);
        tif.irq_meip = mei; tif.irq_msip = msi; tif.irq_mtip = mti;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        clear_commit();
        tif.commit_pc = '0; tif.exc_code = '0; tif.exc_tval = '0; tif.mem_busy = 0;
        set_irq(0, 0, 0);
        tif.mie = 64'h888; tif.mstatus_mie = 1;
        tif.mtvec = 64'h8000_0000; tif.mepc_in = '0;
        step();
        chk_en = 1;
        // an event presented during reset must not be taken
        drive_exc(64'h100, 6'd1, 64'h1);
        @(negedge clk);
        chk("reset_take", 64'(tif.take), 64'd0);
        chk("reset_busy", 64'(tif.busy), 64'd0);
        step();
        reset = 0;
        clear_commit();
        step();

        // plain exception, no drain
        drive_exc(64'h8000_0010, 6'd2, 64'hDEAD);
        run_event(0, 0);
        chk("exc_take_n",   64'(t_take), 64'd0);
        chk("exc_we_n2",    64'(t_we),   64'd2);
        chk("exc_mepc",     o_mepc,      64'h8000_0010);
        chk("exc_mcause",   o_mcause,    64'd2);
        chk("exc_mtval",    o_mtval,     64'hDEAD);
        chk("exc_op",       64'(o_op),   64'd1);
        chk("exc_flush",    64'(o_flush),64'd1);
        chk("exc_rd_n3",    64'(t_rd),   64'd3);
        chk("exc_rpc",      o_rpc,       64'h8000_0000);
        chk("exc_idle_n4",  64'(t_idle), 64'd4);

        // exception beats an enabled MEI, then MEI at the next commit
        set_irq(1, 0, 0);
        drive_exc(64'h8000_0020, 6'd5, 64'h1234);
        run_event(0, 0);
        chk("pri_exc_mcause", o_mcause, 64'd5);
        tif.commit_valid = 1; tif.commit_pc = 64'h8000_0024;
        run_event(0, 0);
        chk("pri_irq_mcause", o_mcause, 64'h8000_0000_0000_000B);
        chk("pri_irq_mtval",  o_mtval,  64'd0);
        chk("pri_irq_mepc",   o_mepc,   64'h8000_0024);

        // interrupt priority among lines
        set_irq(1, 1, 1);
        tif.commit_valid = 1;
        run_event(0, 0);
        chk("irq_all_mcause", o_mcause, 64'h8000_0000_0000_000B);
        set_irq(0, 1, 1);
        tif.commit_valid = 1;
        run_event(0, 0);
        chk("irq_msi_mcause", o_mcause, 64'h8000_0000_0000_0003);
        // global disable
        set_irq(1, 1, 1);
        tif.mstatus_mie = 0;
        tif.commit_valid = 1;
        @(negedge clk);
        chk("irq_mie0_take", 64'(tif.take), 64'd0);
        step();
        // per-line mask: only MEI enabled, only MTI pending
        tif.mstatus_mie = 1; tif.mie = 64'h800;
        set_irq(0, 0, 1);
        @(negedge clk);
        chk("irq_masked_take", 64'(tif.take), 64'd0);
        step();
        clear_commit();
        tif.mie = 64'h888;
        set_irq(0, 0, 0);
        step();

        // drain for 3 cycles with noise on the commit inputs
        drive_exc(64'h8000_0040, 6'd7, 64'hBEEF);
        run_event(3, 1);
        chk("drain_we_n5",   64'(t_we),   64'd5);
        chk("drain_idle_n7", 64'(t_idle), 64'd7);
        chk("drain_mepc",    o_mepc,      64'h8000_0040);
        chk("drain_mtval",   o_mtval,     64'hBEEF);

        // mret, mepc_in changes after capture
        tif.is_mret = 1; tif.commit_valid = 1; tif.mepc_in = 64'h8000_0103;
        run_event(0, 1);
        chk("mret_op_n2", 64'(t_op), 64'd2);
        chk("mret_op",    64'(o_op), 64'd2);
        chk("mret_flush", 64'(o_flush), 64'd1);
        chk("mret_no_we", 64'(t_we == -1), 64'd1);
        chk("mret_rpc",   o_rpc, 64'h8000_0100);

        // vectored mode with MTI, and an exception in the same mode
        tif.mtvec = 64'h8000_0001;
        set_irq(0, 0, 1);
        tif.commit_valid = 1;
        run_event(1, 0);
        chk("vec_mcause", o_mcause, 64'h8000_0000_0000_0007);
`ifdef TRAP_CTRL_VECTORED_EN
        chk("vec_rpc", o_rpc, 64'h8000_001C);
`else
        chk("vec_rpc", o_rpc, 64'h8000_0000);
`endif
        set_irq(0, 0, 0);
        drive_exc(64'h8000_0050, 6'd3, 64'h0);
        run_event(0, 0);
        chk("vec_exc_rpc", o_rpc, 64'h8000_0000);
        tif.mtvec = 64'h8000_0000;

        // reset in the cycle before WRITE
        drive_exc(64'h8000_0060, 6'd4, 64'h44);
        @(negedge clk);
        chk("rst1_take", 64'(tif.take), 64'd1);
        step(); clear_commit(); reset = 1;
        @(negedge clk);
        chk("rst1_busy_drain", 64'(tif.busy), 64'd1);
        step(); reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst1_no_we",  64'(tif.csr_we),         64'd0);
            chk("rst1_no_rd",  64'(tif.redirect_valid), 64'd0);
            chk("rst1_idle",   64'(tif.busy),           64'd0);
            step();
        end

        // reset during WRITE
        drive_exc(64'h8000_0070, 6'd6, 64'h66);
        step(); clear_commit();
        step(); reset = 1;
        @(negedge clk);
        chk("rst2_in_write", 64'(tif.csr_we), 64'd1);
        step(); reset = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst2_no_rd", 64'(tif.redirect_valid), 64'd0);
            chk("rst2_idle",  64'(tif.busy),           64'd0);
            step();
        end

        // back to normal after reset
        drive_exc(64'h8000_0080, 6'd1, 64'h11);
        run_event(0, 0);
        chk("post_rst_mcause", o_mcause, 64'd1);
        chk("post_rst_idle",   64'(t_idle), 64'd4);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have inputs: commit_valid 1 (instruction at commit); commit_pc 64; exc_valid 1; exc_code 6 (exception cause); exc_tval 64; is_mret 1; mem_busy 1 (data access in flight).
REQ-004 The block SHALL have inputs: irq_meip, irq_msip, irq_mtip 1 each (pending lines); mie 64; mstatus_mie 1; mtvec 64; mepc_in 64.
REQ-005 The block SHALL have outputs: take 1 (combinational, kills the committing instruction); busy 1 (front-end/commit stall); csr_we 1; csr_mepc 64; csr_mcause 64; csr_mtval 64; mstatus_op 2 (00 none, 01 trap-enter, 10 mret-exit); flush 1; redirect_valid 1; redirect_pc 64.

Function
REQ-006 The FSM SHALL have states IDLE, DRAIN, WRITE, REDIRECT, one-hot or binary encoded.
REQ-007 An interrupt line i SHALL be enabled when mstatus_mie & mie[i] & irq_i, with i = 11 (MEI), 3 (MSI), 7 (MTI).
REQ-008 Interrupt priority SHALL be MEI > MSI > MTI.
REQ-009 In IDLE with commit_valid=1, the event priority SHALL be exception > enabled interrupt > mret; no event means take=0 and the state stays IDLE.
REQ-010 On any event in IDLE, take SHALL assert in the same cycle N, the block SHALL capture event kind, cause, tval, commit_pc and mepc_in, and the state SHALL be DRAIN at N+1.
REQ-011 DRAIN SHALL hold while mem_busy=1 and advance to WRITE on the edge where mem_busy=0; the minimum DRAIN residency is 1 cycle.
REQ-012 WRITE SHALL last exactly 1 cycle and assert csr_we=1 and flush=1.
REQ-013 Exception values in WRITE SHALL be: csr_mepc = captured pc; csr_mcause = {58'b0, exc_code}; csr_mtval = captured tval; mstatus_op = 01.
REQ-014 Interrupt values in WRITE SHALL be: csr_mepc = captured pc; csr_mcause = {1'b1, 59'b0, code[3:0]}; csr_mtval = 0; mstatus_op = 01.
REQ-015 Mret values in WRITE SHALL be: csr_we=0 for mepc/mcause/mtval (outputs 0); mstatus_op = 10; flush=1.
REQ-016 REDIRECT SHALL last exactly 1 cycle, assert redirect_valid=1, and return to IDLE.
REQ-017 redirect_pc SHALL be {captured mepc_in[63:2], 2'b00} for mret and {mtvec[63:2], 2'b00} for traps, with mtvec sampled in REDIRECT.
REQ-018 busy SHALL be 1 in DRAIN, WRITE and REDIRECT, and 0 in IDLE.
REQ-019 The minimum event-to-IDLE time SHALL be 4 cycles (N..N+3).
REQ-020 While busy=1, commit_valid, exc_valid, is_mret and the irq lines SHALL be ignored; pending interrupts are re-evaluated only in IDLE.
REQ-021 Outside their active states, csr_we, flush, redirect_valid and mstatus_op SHALL be 0 and the data outputs SHALL be 0.

Reset
REQ-022 reset=1 at any edge SHALL force IDLE and clear all captured registers, and take SHALL be 0 during reset.
REQ-023 Reset mid-sequence (DRAIN/WRITE/REDIRECT) SHALL abandon the event with no csr_we or redirect_valid pulse after the reset edge.

Configuration
REQ-024 The macro TRAP_CTRL_VECTORED_EN SHALL control vectored trap entry.
REQ-025 With TRAP_CTRL_VECTORED_EN defined, mtvec[1:0]=01 and an interrupt, redirect_pc SHALL be base + 4*code; exceptions and mode 00 SHALL use base.
REQ-026 Without TRAP_CTRL_VECTORED_EN, mtvec[1:0] SHALL be ignored and all traps SHALL go to base.

Verification
REQ-027 Exception: commit_pc=0x8000_0010, exc_code=2, exc_tval=0xDEAD, mem_busy=0 -> take at N; csr_we at N+2 with mepc 0x8000_0010, mcause 2, mtval 0xDEAD, op 01; redirect to mtvec base at N+3.
REQ-028 Priority: exc_valid plus irq_meip enabled in the same cycle -> exception cause; at the next IDLE commit -> mcause 0x8000_0000_0000_000B.
REQ-029 Interrupts: all three pending and enabled, mstatus_mie=1 -> mcause code 11; with mstatus_mie=0 -> take=0.
REQ-030 Drain: mem_busy held 3 cycles after capture -> WRITE delayed exactly 3 cycles, busy stays high throughout.
REQ-031 Mret and vectoring: mret with mepc_in=0x8000_0103 -> redirect_pc 0x8000_0100, op 10; with TRAP_CTRL_VECTORED_EN, mtvec=0x8000_0001 and MTI -> redirect_pc 0x8000_001C.
REQ-032 Reset in WRITE-1 cycle -> no csr_we, no redirect, IDLE next cycle.
